// File: rtl/wb_master_engine.sv
// Wishbone classic-cycle initiator: one command drives len single-beat reads or writes.
// Define WBM_TIMEOUT_EN to abort a beat that waits TIMEOUT cycles for ack.
module wb_master_engine #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  // Handshakes: a word moves on a clock edge where valid and ready are both high;
  // valid and its payload never change while valid is high and ready is low.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDAT  = 3'd1,
    BUS   = 3'd2,
    RDOUT = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             expire;

  assign state_dbg = state;

`ifdef WBM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;

  // Counts BUS cycles without ack; any cycle outside BUS rearms it for the next beat.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wait_cnt <= '0;
    end else if (state == BUS && !wbm_ack_i) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign expire = (state == BUS) && (wait_cnt == TIMEOUT_LAST);
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      remaining   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_addr & 32'hFFFF_FFFC;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (cmd_we) begin
              state       <= WDAT;
              wdata_ready <= 1'b1;
            end else begin
              state     <= BUS;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 4'hF;
            end
          end
        end
        WDAT: begin
          if (wdata_valid) begin
            wbm_dat_o   <= wdata;
            wdata_ready <= 1'b0;
            state       <= BUS;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            wbm_sel_o   <= 4'hF;
          end
        end
        BUS: begin
          // Ack wins over a simultaneous expiry, so a last-cycle ack still completes the beat.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= 4'h0;
            remaining <= remaining - LEN_W'(1);
            wbm_adr_o <= wbm_adr_o + 32'd4;
            if (!wbm_we_o) begin
              rdata       <= wbm_dat_i;
              rdata_valid <= 1'b1;
              state       <= RDOUT;
            end else if (remaining == LEN_W'(1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= WDAT;
              wdata_ready <= 1'b1;
            end
          end else if (expire) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= 4'h0;
            err       <= 1'b1;
            state     <= FIN;
            done      <= 1'b1;
          end
        end
        RDOUT: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            if (remaining == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= BUS;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 4'hF;
            end
          end
        end
        FIN: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
